// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: one FSM state per instruction phase, driving
// every datapath select/enable and stalling on the req/ready memory port with timeout.
module mc_ctrl_fsm #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic       btaken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic       csr_en,
    output logic       trap,
    output logic [3:0] state_o
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    localparam logic [1:0] A_PC     = 2'b00;
    localparam logic [1:0] A_OLDPC  = 2'b01;
    localparam logic [1:0] A_RS1    = 2'b10;
    localparam logic [1:0] A_ZERO   = 2'b11;
    localparam logic [1:0] B_RS2    = 2'b00;
    localparam logic [1:0] B_IMM    = 2'b01;
    localparam logic [1:0] B_FOUR   = 2'b10;
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;
    localparam logic [1:0] RES_AOUT = 2'b00;
    localparam logic [1:0] RES_MEM  = 2'b01;
    localparam logic [1:0] RES_ALU  = 2'b10;
    localparam logic [1:0] RES_CSR  = 2'b11;
    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_J    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;

    // The wait counter holds the number of cycles already spent waiting, so the
    // access times out on the cycle where that count reaches TIMEOUT-1 unanswered.
    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT - 1) : '0;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWR  = 4'd4,
        MEMWB  = 4'd5,
        EXER   = 4'd6,
        EXEI   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JAL    = 4'd10,
        JALR   = 4'd11,
        LUI    = 4'd12,
        AUIPC  = 4'd13,
        CSR    = 4'd14,
        TRAP   = 4'd15
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        logic       csr_en;
        logic       trap;
    } ctrl_t;

    state_t          state, state_next;
    logic [TO_W-1:0] wait_cnt, wait_cnt_next;
    logic            mem_phase;
    logic            timed_out;
    ctrl_t           ctrl, ctrl_out;

    assign mem_phase = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    assign timed_out = TO_EN && mem_phase && !mem_ready && (wait_cnt >= TO_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; reset is synchronous, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Counter only runs while a memory state is stalled; it is zero everywhere else,
    // which gives the clear-on-entry behaviour for FETCH/MEMRD/MEMWR for free.
    always_comb begin
        wait_cnt_next = '0;
        if (mem_phase && !mem_ready) begin
            wait_cnt_next = (&wait_cnt) ? wait_cnt : wait_cnt + TO_W'(1);
        end
    end

    // NOTE: next state defaults to the current state before the case statement,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (mem_ready)      state_next = DECODE;
                else if (timed_out) state_next = TRAP;
            end
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_R:              state_next = EXER;
                    OP_I:              state_next = EXEI;
                    OP_BR:             state_next = BRANCH;
                    OP_JAL:            state_next = JAL;
                    OP_JALR:           state_next = JALR;
                    OP_LUI:            state_next = LUI;
                    OP_AUIPC:          state_next = AUIPC;
                    OP_SYS:            state_next = CSR;
                    default:           state_next = TRAP;
                endcase
            end
            MEMADR: state_next = (opcode == OP_STORE) ? MEMWR : MEMRD;
            MEMRD: begin
                if (mem_ready)      state_next = MEMWB;
                else if (timed_out) state_next = TRAP;
            end
            MEMWR: begin
                if (mem_ready)      state_next = FETCH;
                else if (timed_out) state_next = TRAP;
            end
            MEMWB:  state_next = FETCH;
            EXER:   state_next = ALUWB;
            EXEI:   state_next = ALUWB;
            ALUWB:  state_next = FETCH;
            BRANCH: state_next = FETCH;
            JALR:   state_next = JAL;
            JAL:    state_next = ALUWB;
            LUI:    state_next = ALUWB;
            AUIPC:  state_next = ALUWB;
            CSR:    state_next = FETCH;
            TRAP:   state_next = TRAP;
            default: state_next = TRAP;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = A_PC;
                ctrl.alu_src_b  = B_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.result_src = RES_ALU;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_write   = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_a = A_OLDPC;
                ctrl.alu_src_b = B_IMM;
                ctrl.alu_op    = ALU_ADD;
                if (opcode == OP_BR)       ctrl.imm_src = IMM_B;
                else if (opcode == OP_JAL) ctrl.imm_src = IMM_J;
                else                       ctrl.imm_src = IMM_I;
            end
            MEMADR: begin
                ctrl.alu_src_a = A_RS1;
                ctrl.alu_src_b = B_IMM;
                ctrl.imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.adr_src   = 1'b1;
            end
            MEMWB: begin
                ctrl.result_src = RES_MEM;
                ctrl.reg_write  = 1'b1;
            end
            EXER: begin
                ctrl.alu_src_a = A_RS1;
                ctrl.alu_src_b = B_RS2;
                ctrl.alu_op    = ALU_FUNC;
            end
            EXEI: begin
                ctrl.alu_src_a = A_RS1;
                ctrl.alu_src_b = B_IMM;
                ctrl.alu_op    = ALU_FUNC;
            end
            ALUWB: begin
                ctrl.result_src = RES_AOUT;
                ctrl.reg_write  = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a  = A_RS1;
                ctrl.alu_src_b  = B_RS2;
                ctrl.alu_op     = ALU_SUB;
                ctrl.result_src = RES_AOUT;
                ctrl.pc_write   = btaken;
            end
            JALR: begin
                ctrl.alu_src_a = A_RS1;
                ctrl.alu_src_b = B_IMM;
                ctrl.imm_src   = IMM_I;
            end
            // ALUOut already holds the jump target; the ALU forms OldPC+4 for ALUWB.
            JAL: begin
                ctrl.alu_src_a  = A_OLDPC;
                ctrl.alu_src_b  = B_FOUR;
                ctrl.result_src = RES_AOUT;
                ctrl.pc_write   = 1'b1;
            end
            LUI: begin
                ctrl.alu_src_a = A_ZERO;
                ctrl.alu_src_b = B_IMM;
                ctrl.imm_src   = IMM_U;
            end
            AUIPC: begin
                ctrl.alu_src_a = A_OLDPC;
                ctrl.alu_src_b = B_IMM;
                ctrl.imm_src   = IMM_U;
            end
            CSR: begin
                ctrl.csr_en     = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_CSR;
            end
            TRAP:    ctrl.trap = 1'b1;
            default: ctrl.trap = 1'b1;
        endcase
    end

    // Reset masks every output immediately, even in the middle of a memory access.
    assign ctrl_out = reset_n ? ctrl : '0;
    assign state_o  = reset_n ? state : FETCH;

    assign mem_req    = ctrl_out.mem_req;
    assign mem_write  = ctrl_out.mem_write;
    assign adr_src    = ctrl_out.adr_src;
    assign ir_write   = ctrl_out.ir_write;
    assign pc_write   = ctrl_out.pc_write;
    assign reg_write  = ctrl_out.reg_write;
    assign alu_src_a  = ctrl_out.alu_src_a;
    assign alu_src_b  = ctrl_out.alu_src_b;
    assign alu_op     = ctrl_out.alu_op;
    assign result_src = ctrl_out.result_src;
    assign imm_src    = ctrl_out.imm_src;
    assign csr_en     = ctrl_out.csr_en;
    assign trap       = ctrl_out.trap;

endmodule
